brick_field_engine: RTL and testbench
=====================================

BRICK_FIELD_ENGINE -- requirements
Module: brick_field_engine

Interface
REQ-001 Parameters (name, default, meaning): COLS, 10, bricks per row; ROWS, 5, brick rows; BRICK_W, 16, brick width px; BRICK_H, 8, brick height px; X0, 0, field left x; Y0, 0, field top y; ADDR_W, 8, RAM address width; BRICK_COLOUR, 3'b100, fixed brick colour.
REQ-002 Ports (name direction width meaning), N = COLS*ROWS: clk in 1 system clock; reset in 1 async active-high reset.
REQ-003 start_init in 1 request field build+draw; erase_req in 1 request brick erase; erase_row in 8 target row; erase_col in 8 target column.
REQ-004 busy out 1 operation in progress; done out 1 one-cycle completion pulse; erase_miss out 1 one-cycle pulse, erase rejected.
REQ-005 ram_wren out 1 record write strobe; ram_addr out ADDR_W record address; ram_wdata out 18 record {colour[17:15], y[14:8], x[7:0]}.
REQ-006 x out 8 pixel x; y out 7 pixel y; colour out 3 pixel colour; plot out 1 pixel write strobe.
REQ-007 alive out N per-brick alive bitmap, bit i = row*COLS+col; bricks_left out 8 count of alive bricks.

Function
REQ-008 FSM states IDLE, STORE, DRAW, ERASE, FINISH; busy = 1 in every state except IDLE.
REQ-009 IDLE: start_init -> STORE; else erase_req -> ERASE check; start_init wins when both high; requests while busy are ignored, not queued.
REQ-010 STORE: N cycles, one record per cycle, ram_wren=1, ram_addr=i for i=0..N-1 in row-major order.
REQ-011 Record x = X0 + col*BRICK_W, y = Y0 + row*BRICK_H, generated by col/row counters (no divide); col wraps COLS-1 -> 0 with row+1.
REQ-012 STORE sets alive bit i as record i is written; bricks_left = N when STORE ends.
REQ-013 DRAW: raster every brick in index order, pixels px 0..BRICK_W-1 inner, py 0..BRICK_H-1 outer; one pixel per cycle, plot=1; exactly N*BRICK_W*BRICK_H cycles.
REQ-014 DRAW pixel = (brick x + px, brick y + py), colour = brick colour.
REQ-015 Erase check, first ERASE cycle: erase_row >= ROWS, erase_col >= COLS or brick already dead -> erase_miss=1 and done=1 in the same cycle, return to IDLE, no plot, no state change.
REQ-016 Valid erase: clear alive bit, decrement bricks_left, plot BRICK_W*BRICK_H pixels colour 3'b000 over brick rectangle, same raster order.
REQ-017 FINISH: done=1 for exactly one cycle, then IDLE; ram_wren, plot = 0 outside STORE/DRAW/ERASE.
REQ-018 Pixel x, y computed at full width then truncated to 8/7 bits; bench-visible geometry never exceeds 160x120 at defaults.
REQ-019 start_init while bricks exist: rebuild from scratch, all bricks alive again.
REQ-020 Latency: busy rises on the cycle after the accepted request; first ram_wren or plot occurs that same cycle.

Reset
REQ-021 Reset asynchronous, active-high, effective immediately, including mid-operation.
REQ-022 Reset values: state IDLE, busy=0, done=0, erase_miss=0, ram_wren=0, ram_addr=0, ram_wdata=0, x=0, y=0, colour=0, plot=0, alive=0, bricks_left=0, all counters 0.
REQ-023 Partially written RAM or partially drawn screen after reset is not repaired; the next start_init restores it.

Configuration
REQ-024 Macro BRICK_ROW_COLOURS_EN defined: brick colour = (row mod 6) + 1, i.e. rows 0..5 -> 3'b001..3'b110, repeating.
REQ-025 Macro not defined: every brick colour = BRICK_COLOUR; all other behaviour identical.

Verification
REQ-026 Defaults, pulse start_init -> 50 writes; addr 0 = {100,0,0}, addr 9 = {100,0,144}, addr 10 = {100,8,0}, addr 49 = {100,32,144}; alive all 1, bricks_left=50.
REQ-027 After init: exactly 6400 plot cycles, last pixel (159,39), then single done pulse, busy=0.
REQ-028 erase_row=2, erase_col=3 -> 128 black pixels over x 48..63, y 16..23; alive[23]=0; bricks_left=49; done pulse.
REQ-029 Repeat same erase -> erase_miss=1, done=1 same cycle, no plot; erase_col=10 -> erase_miss.
REQ-030 start_init and erase_req high together in IDLE -> init runs; reset asserted mid-DRAW -> all outputs zero immediately, busy=0.
REQ-031 BRICK_ROW_COLOURS_EN defined -> row 0 records colour 3'b001, row 4 colour 3'b101.

Source files
------------

// File: rtl/brick_field_if.sv
// Request/status, RAM record and pixel signals of the brick field engine.
// The engine uses the slave modport; whoever drives requests uses master.
interface brick_field_if #(
    parameter int N      = 50,
    parameter int ADDR_W = 8
);
    logic              start_init;
    logic              erase_req;
    logic [7:0]        erase_row;
    logic [7:0]        erase_col;
    logic              busy;
    logic              done;
    logic              erase_miss;
    logic              ram_wren;
    logic [ADDR_W-1:0] ram_addr;
    logic [17:0]       ram_wdata;
    logic [7:0]        x;
    logic [6:0]        y;
    logic [2:0]        colour;
    logic              plot;
    logic [N-1:0]      alive;
    logic [7:0]        bricks_left;

    modport master (
        output start_init, erase_req, erase_row, erase_col,
        input  busy, done, erase_miss, ram_wren, ram_addr, ram_wdata,
        input  x, y, colour, plot, alive, bricks_left
    );

    modport slave (
        input  start_init, erase_req, erase_row, erase_col,
        output busy, done, erase_miss, ram_wren, ram_addr, ram_wdata,
        output x, y, colour, plot, alive, bricks_left
    );
endinterface

// File: rtl/brick_field_engine.sv
// Builds the brick record table in RAM, rasters every brick, and erases single bricks.
// Optional macro BRICK_ROW_COLOURS_EN: brick colour = (row mod 6) + 1 instead of BRICK_COLOUR.
module brick_field_engine #(
    parameter int         COLS         = 10,
    parameter int         ROWS         = 5,
    parameter int         BRICK_W      = 16,
    parameter int         BRICK_H      = 8,
    parameter int         X0           = 0,
    parameter int         Y0           = 0,
    parameter int         ADDR_W       = 8,
    parameter logic [2:0] BRICK_COLOUR = 3'b100
) (
    input  logic         clk,
    input  logic         reset,
    brick_field_if.slave bus
);
    localparam int          N        = COLS * ROWS;
    localparam logic [N-1:0] ONE     = N'(1);
    localparam logic [15:0] BW       = 16'(BRICK_W);
    localparam logic [15:0] BH       = 16'(BRICK_H);
    localparam logic [15:0] XS       = 16'(X0);
    localparam logic [15:0] YS       = 16'(Y0);
    localparam logic [7:0]  LAST_COL = 8'(COLS - 1);
    localparam logic [7:0]  LAST_PX  = 8'(BRICK_W - 1);
    localparam logic [7:0]  LAST_PY  = 8'(BRICK_H - 1);
    localparam logic [15:0] LAST_IDX = 16'(N - 1);

    typedef enum logic [2:0] {IDLE, STORE, DRAW, ERASE, FINISH} state_t;

    state_t       state_q, state_d;
    logic [15:0]  brickIdx_q, brickIdx_d;
    logic [7:0]   col_q, col_d, row_q, row_d;
    logic [15:0]  baseX_q, baseX_d, baseY_q, baseY_d;
    logic [7:0]   px_q, px_d, py_q, py_d;
    logic [7:0]   erRow_q, erRow_d, erCol_q, erCol_d;
    logic [15:0]  erX_q, erX_d, erY_q, erY_d;
    logic [N-1:0] alive_q, alive_d;
    logic [7:0]   left_q, left_d;

    logic [7:0]   nCol, nRow;
    logic [15:0]  nBaseX, nBaseY;
    logic [2:0]   brickColour;
    logic [15:0]  erIdx;
    logic [N-1:0] aliveAt;
    logic         hit, lastPixel;

    logic              busyO, doneO, missO, wrenO, plotO;
    logic [ADDR_W-1:0] addrO;
    logic [17:0]       wdataO;
    logic [7:0]        xO;
    logic [6:0]        yO;
    logic [2:0]        colourO;

`ifdef BRICK_ROW_COLOURS_EN
    assign brickColour = 3'((row_q % 8'd6) + 8'd1);
`else
    assign brickColour = BRICK_COLOUR;
`endif

    // Erase target is validated against the latched request, never the live inputs.
    assign erIdx     = 16'(erRow_q) * 16'(COLS) + 16'(erCol_q);
    assign aliveAt   = alive_q >> erIdx;
    assign hit       = (erRow_q < 8'(ROWS)) && (erCol_q < 8'(COLS)) && aliveAt[0];
    assign lastPixel = (px_q == LAST_PX) && (py_q == LAST_PY);

    // Row-major brick stepping: position is tracked incrementally, never divided out of the index.
    always_comb begin
        if (col_q == LAST_COL) begin
            nCol   = 8'd0;
            nRow   = row_q + 8'd1;
            nBaseX = XS;
            nBaseY = baseY_q + BH;
        end else begin
            nCol   = col_q + 8'd1;
            nRow   = row_q;
            nBaseX = baseX_q + BW;
            nBaseY = baseY_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        brickIdx_d = brickIdx_q;
        col_d      = col_q;
        row_d      = row_q;
        baseX_d    = baseX_q;
        baseY_d    = baseY_q;
        px_d       = px_q;
        py_d       = py_q;
        erRow_d    = erRow_q;
        erCol_d    = erCol_q;
        erX_d      = erX_q;
        erY_d      = erY_q;
        alive_d    = alive_q;
        left_d     = left_q;
        busyO      = (state_q != IDLE);
        doneO      = 1'b0;
        missO      = 1'b0;
        wrenO      = 1'b0;
        plotO      = 1'b0;
        addrO      = '0;
        wdataO     = '0;
        xO         = '0;
        yO         = '0;
        colourO    = '0;

        case (state_q)
            IDLE: begin
                if (bus.start_init) begin
                    state_d    = STORE;
                    brickIdx_d = '0;
                    col_d      = '0;
                    row_d      = '0;
                    baseX_d    = XS;
                    baseY_d    = YS;
                    alive_d    = '0;
                    left_d     = '0;
                end else if (bus.erase_req) begin
                    state_d = ERASE;
                    erRow_d = bus.erase_row;
                    erCol_d = bus.erase_col;
                    erX_d   = XS + 16'(bus.erase_col) * BW;
                    erY_d   = YS + 16'(bus.erase_row) * BH;
                    px_d    = '0;
                    py_d    = '0;
                end
            end

            STORE: begin
                wrenO      = 1'b1;
                addrO      = brickIdx_q[ADDR_W-1:0];
                wdataO     = {brickColour, baseY_q[6:0], baseX_q[7:0]};
                alive_d    = alive_q | (ONE << brickIdx_q);
                left_d     = left_q + 8'd1;
                brickIdx_d = brickIdx_q + 16'd1;
                col_d      = nCol;
                row_d      = nRow;
                baseX_d    = nBaseX;
                baseY_d    = nBaseY;
                if (brickIdx_q == LAST_IDX) begin
                    state_d    = DRAW;
                    brickIdx_d = '0;
                    col_d      = '0;
                    row_d      = '0;
                    baseX_d    = XS;
                    baseY_d    = YS;
                    px_d       = '0;
                    py_d       = '0;
                end
            end

            DRAW: begin
                plotO   = 1'b1;
                xO      = 8'(baseX_q + 16'(px_q));
                yO      = 7'(baseY_q + 16'(py_q));
                colourO = brickColour;
                if (px_q == LAST_PX) begin
                    px_d = '0;
                    if (py_q == LAST_PY) begin
                        py_d       = '0;
                        brickIdx_d = brickIdx_q + 16'd1;
                        col_d      = nCol;
                        row_d      = nRow;
                        baseX_d    = nBaseX;
                        baseY_d    = nBaseY;
                        if (brickIdx_q == LAST_IDX) state_d = FINISH;
                    end else begin
                        py_d = py_q + 8'd1;
                    end
                end else begin
                    px_d = px_q + 8'd1;
                end
            end

            // Pixel (0,0) is only ever seen on the first ERASE cycle, so it doubles as the check cycle.
            ERASE: begin
                if (px_q == 8'd0 && py_q == 8'd0 && !hit) begin
                    missO   = 1'b1;
                    doneO   = 1'b1;
                    state_d = IDLE;
                end else begin
                    plotO = 1'b1;
                    xO    = 8'(erX_q + 16'(px_q));
                    yO    = 7'(erY_q + 16'(py_q));
                    if (px_q == 8'd0 && py_q == 8'd0) begin
                        alive_d = alive_q & ~(ONE << erIdx);
                        left_d  = left_q - 8'd1;
                    end
                    if (lastPixel) begin
                        state_d = FINISH;
                        px_d    = '0;
                        py_d    = '0;
                    end else if (px_q == LAST_PX) begin
                        px_d = '0;
                        py_d = py_q + 8'd1;
                    end else begin
                        px_d = px_q + 8'd1;
                    end
                end
            end

            FINISH: begin
                doneO   = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            brickIdx_q <= '0;
            col_q      <= '0;
            row_q      <= '0;
            baseX_q    <= '0;
            baseY_q    <= '0;
            px_q       <= '0;
            py_q       <= '0;
            erRow_q    <= '0;
            erCol_q    <= '0;
            erX_q      <= '0;
            erY_q      <= '0;
            alive_q    <= '0;
            left_q     <= '0;
        end else begin
            state_q    <= state_d;
            brickIdx_q <= brickIdx_d;
            col_q      <= col_d;
            row_q      <= row_d;
            baseX_q    <= baseX_d;
            baseY_q    <= baseY_d;
            px_q       <= px_d;
            py_q       <= py_d;
            erRow_q    <= erRow_d;
            erCol_q    <= erCol_d;
            erX_q      <= erX_d;
            erY_q      <= erY_d;
            alive_q    <= alive_d;
            left_q     <= left_d;
        end
    end

    assign bus.busy        = busyO;
    assign bus.done        = doneO;
    assign bus.erase_miss  = missO;
    assign bus.ram_wren    = wrenO;
    assign bus.ram_addr    = addrO;
    assign bus.ram_wdata   = wdataO;
    assign bus.x           = xO;
    assign bus.y           = yO;
    assign bus.colour      = colourO;
    assign bus.plot        = plotO;
    assign bus.alive       = alive_q;
    assign bus.bricks_left = left_q;
endmodule

// File: tb/tb_brick_field_engine.sv
// Scoreboard bench for brick_field_engine: expected RAM writes, pixels and done pulses are
// queued with each request and a negedge monitor pops and compares every DUT strobe.
module tb_brick_field_engine;
    localparam int COLS   = 10;
    localparam int ROWS   = 5;
    localparam int N      = 50;
    localparam int K_WR   = 0;
    localparam int K_PIX  = 1;
    localparam int K_DONE = 2;

    typedef struct {
        int          kind;
        logic [31:0] v;
    } ev_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    brick_field_if #(.N(N), .ADDR_W(8)) bus ();

    brick_field_engine dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    ev_t         expQ[$];
    int          total = 0;
    int          bad   = 0;
    logic [17:0] ram[0:255];
    logic [14:0] lastPix;

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [2:0] expColour(input int r);
`ifdef BRICK_ROW_COLOURS_EN
        return 3'(r % 6 + 1);
`else
        return 3'b100;
`endif
    endfunction

    function automatic logic [63:0] outVec();
        return 64'({bus.busy, bus.done, bus.erase_miss, bus.ram_wren, bus.ram_addr, bus.ram_wdata,
                    bus.x, bus.y, bus.colour, bus.plot, bus.bricks_left});
    endfunction

    task automatic pushInit();
        ev_t e;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                e.kind = K_WR;
                e.v    = {6'd0, 8'(r * COLS + c), expColour(r), 7'(r * 8), 8'(c * 16)};
                expQ.push_back(e);
            end
        for (int b = 0; b < N; b++)
            for (int py = 0; py < 8; py++)
                for (int px = 0; px < 16; px++) begin
                    e.kind = K_PIX;
                    e.v    = {14'd0, 8'((b % COLS) * 16 + px), 7'((b / COLS) * 8 + py), expColour(b / COLS)};
                    expQ.push_back(e);
                end
        e.kind = K_DONE;
        e.v    = 32'd2;
        expQ.push_back(e);
    endtask

    task automatic pushErase(input int r, input int c);
        ev_t e;
        for (int py = 0; py < 8; py++)
            for (int px = 0; px < 16; px++) begin
                e.kind = K_PIX;
                e.v    = {14'd0, 8'(c * 16 + px), 7'(r * 8 + py), 3'b000};
                expQ.push_back(e);
            end
        e.kind = K_DONE;
        e.v    = 32'd2;
        expQ.push_back(e);
    endtask

    task automatic pushMiss();
        ev_t e;
        e.kind = K_DONE;
        e.v    = 32'd3;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic si, input logic er, input int row, input int col);
        @(negedge clk);
        bus.start_init = si;
        bus.erase_req  = er;
        bus.erase_row  = 8'(row);
        bus.erase_col  = 8'(col);
        @(posedge clk);
        #1;
        bus.start_init = 1'b0;
        bus.erase_req  = 1'b0;
        checkOutput("busy_after_request", 64'(bus.busy), 64'd1);
        checkOutput("first_strobe", 64'(bus.ram_wren | bus.plot | bus.erase_miss), 64'd1);
    endtask

    task automatic waitDrain(input int limit);
        int n = 0;
        while (expQ.size() != 0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        checkOutput("drain_pending", 64'(expQ.size()), 64'd0);
        expQ.delete();
        @(posedge clk);
        #1;
        checkOutput("idle_busy", 64'(bus.busy), 64'd0);
    endtask

    always @(negedge clk) begin
        ev_t obs;
        ev_t want;
        if (!reset && (bus.ram_wren || bus.plot || bus.done || bus.erase_miss)) begin
            if (bus.ram_wren) begin
                obs.kind = K_WR;
                obs.v    = {6'd0, bus.ram_addr, bus.ram_wdata};
                ram[bus.ram_addr] = bus.ram_wdata;
            end else if (bus.plot) begin
                obs.kind = K_PIX;
                obs.v    = {14'd0, bus.x, bus.y, bus.colour};
                lastPix  = {bus.x, bus.y};
            end else begin
                obs.kind = K_DONE;
                obs.v    = {30'd0, bus.done, bus.erase_miss};
            end
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_event: got kind=%0d value=%0h, required no event", obs.kind, obs.v);
            end else begin
                want = expQ.pop_front();
                checkOutput(want.kind == K_WR ? "ram_write" : (want.kind == K_PIX ? "pixel" : "done_pulse"),
                            {32'(obs.kind), obs.v}, {32'(want.kind), want.v});
            end
        end
    end

    initial begin
        bus.start_init = 1'b0;
        bus.erase_req  = 1'b0;
        bus.erase_row  = 8'd0;
        bus.erase_col  = 8'd0;
        #12;
        checkOutput("reset_outputs", outVec(), 64'd0);
        checkOutput("reset_alive", 64'(bus.alive), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] field build and draw");
        pushInit();
        applyStimulus(1'b1, 1'b0, 0, 0);
        waitDrain(8000);
        checkOutput("ram_addr0", 64'(ram[0]), 64'({expColour(0), 7'd0, 8'd0}));
        checkOutput("ram_addr9", 64'(ram[9]), 64'({expColour(0), 7'd0, 8'd144}));
        checkOutput("ram_addr10", 64'(ram[10]), 64'({expColour(1), 7'd8, 8'd0}));
        checkOutput("ram_addr49", 64'(ram[49]), 64'({expColour(4), 7'd32, 8'd144}));
        checkOutput("last_draw_pixel", 64'(lastPix), 64'({8'd159, 7'd39}));
        checkOutput("alive_after_init", 64'(bus.alive), 64'({N{1'b1}}));
        checkOutput("bricks_after_init", 64'(bus.bricks_left), 64'd50);

        $display("[TB] erase row 2 col 3");
        pushErase(2, 3);
        applyStimulus(1'b0, 1'b1, 2, 3);
        waitDrain(500);
        checkOutput("last_erase_pixel", 64'(lastPix), 64'({8'd63, 7'd23}));
        checkOutput("alive_bit23", 64'(bus.alive[23]), 64'd0);
        checkOutput("alive_after_erase", 64'(bus.alive), 64'({N{1'b1}} & ~(50'd1 << 23)));
        checkOutput("bricks_after_erase", 64'(bus.bricks_left), 64'd49);

        $display("[TB] rejected erases");
        pushMiss();
        applyStimulus(1'b0, 1'b1, 2, 3);
        waitDrain(50);
        pushMiss();
        applyStimulus(1'b0, 1'b1, 0, 10);
        waitDrain(50);
        pushMiss();
        applyStimulus(1'b0, 1'b1, 5, 0);
        waitDrain(50);
        checkOutput("bricks_after_miss", 64'(bus.bricks_left), 64'd49);

        $display("[TB] init wins over erase, busy requests ignored");
        pushInit();
        applyStimulus(1'b1, 1'b1, 2, 4);
        repeat (5) @(negedge clk);
        bus.erase_req = 1'b1;
        bus.erase_row = 8'd0;
        bus.erase_col = 8'd0;
        repeat (3) @(negedge clk);
        bus.erase_req = 1'b0;
        waitDrain(8000);
        checkOutput("alive_after_rebuild", 64'(bus.alive), 64'({N{1'b1}}));
        checkOutput("bricks_after_rebuild", 64'(bus.bricks_left), 64'd50);

        $display("[TB] reset during draw");
        pushInit();
        applyStimulus(1'b1, 1'b0, 0, 0);
        repeat (300) @(posedge clk);
        #2;
        checkOutput("mid_draw_plot", 64'(bus.plot), 64'd1);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("reset_mid_draw", outVec(), 64'd0);
        checkOutput("reset_mid_alive", 64'(bus.alive), 64'd0);
        expQ.delete();
        @(negedge clk);
        reset = 1'b0;

        pushMiss();
        applyStimulus(1'b0, 1'b1, 0, 0);
        waitDrain(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
